// File: rtl/bitwise_logic_pipe_if.sv
// Operand/result handshake bundle for the bitwise logic pipe.
// The master drives operands and accepts results; the slave is the pipe itself.
interface bitwise_logic_pipe_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] C;
    logic         zero;
    logic         parity;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, C, zero, parity
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, C, zero, parity
    );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Two-stage N-bit bitwise logic unit (8 ops) with zero/parity flags.
// Both stages use valid/ready handshakes and stall cleanly under backpressure.
module bitwise_logic_pipe #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    bitwise_logic_pipe_if.slave  bus
);

    logic [N-1:0] a_p1;
    logic [N-1:0] b_p1;
    logic [2:0]   op_p1;
    logic         vld_p1;

    logic [N-1:0] c_p2;
    logic         zero_p2;
    logic         parity_p2;
    logic         vld_p2;

    logic         adv2;
    logic         in_ready;
    logic         ld1;
    logic [N-1:0] res_p1;

    function automatic logic [N-1:0] logic_op(input logic [2:0] sel,
                                              input logic [N-1:0] a,
                                              input logic [N-1:0] b);
        logic [N-1:0] r;
        case (sel)
            3'b000:  r = ~a;
            3'b001:  r = a & b;
            3'b010:  r = a | b;
            3'b011:  r = a ^ b;
            3'b100:  r = ~(a & b);
            3'b101:  r = ~(a | b);
            3'b110:  r = ~(a ^ b);
            default: r = a & ~b;
        endcase
        return r;
    endfunction

    assign adv2     = vld_p1 & (~vld_p2 | bus.out_ready);
    assign in_ready = ~flush & (~vld_p1 | adv2);
    assign ld1      = bus.in_valid & in_ready;
    assign res_p1   = logic_op(op_p1, a_p1, b_p1);

    // Stage 1: operand capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            b_p1   <= '0;
            op_p1  <= '0;
        end else begin
            if (flush)     vld_p1 <= 1'b0;
            else if (ld1)  vld_p1 <= 1'b1;
            else if (adv2) vld_p1 <= 1'b0;

            // ld1 is already gated by flush through in_ready
            if (ld1) begin
                a_p1  <= bus.A;
                b_p1  <= bus.B;
                op_p1 <= bus.op;
            end
        end
    end

    // Stage 2: result and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            c_p2      <= '0;
            zero_p2   <= 1'b1;
            parity_p2 <= 1'b0;
        end else begin
            if (flush)                      vld_p2 <= 1'b0;
            else if (adv2)                  vld_p2 <= 1'b1;
            else if (vld_p2 & bus.out_ready) vld_p2 <= 1'b0;

            if (adv2 & ~flush) begin
                c_p2      <= res_p1;
                zero_p2   <= ~|res_p1;
                parity_p2 <= ^res_p1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p2;
    assign bus.C         = c_p2;
    assign bus.zero      = zero_p2;
    assign bus.parity    = parity_p2;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed bench for bitwise_logic_pipe: an N=8 and an N=32 instance,
// covering latency, op coverage, flags, backpressure, flush and async reset.
module tb_bitwise_logic_pipe;

    logic clk;
    logic rst;
    logic flush8;
    logic flush32;

    int n_checks = 0;
    int n_fail   = 0;

    bitwise_logic_pipe_if #(.N(8))  bus8  ();
    bitwise_logic_pipe_if #(.N(32)) bus32 ();

    bitwise_logic_pipe #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush8),
        .bus   (bus8)
    );

    bitwise_logic_pipe #(.N(32)) u_dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush32),
        .bus   (bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp2 [8] = '{32'h0000FFFF, 32'hFF000000, 32'hFFFFFF00, 32'h00FFFF00,
                              32'h00FFFFFF, 32'h000000FF, 32'hFF0000FF, 32'h00FF0000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic vld, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        bus32.in_valid = vld;
        bus32.op       = op;
        bus32.A        = a;
        bus32.B        = b;
    endtask

    initial begin
        rst = 1'b1;
        flush8 = 1'b0;
        flush32 = 1'b0;
        bus8.in_valid = 1'b0;  bus8.op = 3'd0;  bus8.A = '0;  bus8.B = '0;  bus8.out_ready = 1'b1;
        drive32(1'b0, 3'd0, 32'h0, 32'h0);
        bus32.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus32.out_valid), 32'd0);
        check("rst_C",         bus32.C,              32'd0);
        check("rst_zero",      32'(bus32.zero),      32'd1);
        check("rst_parity",    32'(bus32.parity),    32'd0);
        check("rst_C8",        32'(bus8.C),          32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready",  32'(bus32.in_ready),  32'd1);

        // 1: N=8 NOT, latency of exactly two cycles
        bus8.in_valid = 1'b1; bus8.op = 3'b000; bus8.A = 8'h0F; bus8.B = 8'h00;
        check("t1_in_ready", 32'(bus8.in_ready), 32'd1);
        step();
        bus8.in_valid = 1'b0;
        check("t1_ov_t1", 32'(bus8.out_valid), 32'd0);
        step();
        check("t1_ov_t2",   32'(bus8.out_valid), 32'd1);
        check("t1_C",       32'(bus8.C),         32'h000000F0);
        check("t1_zero",    32'(bus8.zero),      32'd0);
        check("t1_parity",  32'(bus8.parity),    32'd0);
        step();
        check("t1_ov_done", 32'(bus8.out_valid), 32'd0);

        // 3: N=8 XOR flags
        bus8.in_valid = 1'b1; bus8.op = 3'b011; bus8.A = 8'hA5; bus8.B = 8'hA5;
        step();
        bus8.A = 8'h01; bus8.B = 8'h00;
        step();
        bus8.in_valid = 1'b0;
        check("t3a_ov",     32'(bus8.out_valid), 32'd1);
        check("t3a_C",      32'(bus8.C),         32'h0);
        check("t3a_zero",   32'(bus8.zero),      32'd1);
        check("t3a_parity", 32'(bus8.parity),    32'd0);
        step();
        check("t3b_ov",     32'(bus8.out_valid), 32'd1);
        check("t3b_C",      32'(bus8.C),         32'h01);
        check("t3b_zero",   32'(bus8.zero),      32'd0);
        check("t3b_parity", 32'(bus8.parity),    32'd1);
        step();

        // 2: N=32, all eight ops streamed back-to-back
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive32(1'b1, 3'(i), 32'hFFFF0000, 32'hFF00FF00);
            else       drive32(1'b0, 3'd0, 32'h0, 32'h0);
            if (i >= 2) begin
                check($sformatf("t2_ov_%0d", i - 2), 32'(bus32.out_valid), 32'd1);
                check($sformatf("t2_C_%0d", i - 2),  bus32.C,              exp2[i-2]);
            end
            step();
        end
        check("t2_drained", 32'(bus32.out_valid), 32'd0);

        // 4: backpressure, three beats offered with out_ready low
        bus32.out_ready = 1'b0;
        drive32(1'b1, 3'b001, 32'h11, 32'hFFFFFFFF);
        step();
        check("t4_ready_b2", 32'(bus32.in_ready), 32'd1);
        drive32(1'b1, 3'b001, 32'h22, 32'hFFFFFFFF);
        step();
        drive32(1'b1, 3'b001, 32'h33, 32'hFFFFFFFF);
        check("t4_full_ready", 32'(bus32.in_ready), 32'd0);
        check("t4_ov",         32'(bus32.out_valid), 32'd1);
        check("t4_hold_C0",    bus32.C, 32'h11);
        step();
        step();
        check("t4_still_full", 32'(bus32.in_ready), 32'd0);
        check("t4_hold_C1",    bus32.C, 32'h11);
        bus32.out_ready = 1'b1;
        #1;
        check("t4_ready_drain", 32'(bus32.in_ready), 32'd1);
        check("t4_beat1",       bus32.C, 32'h11);
        step();
        drive32(1'b0, 3'd0, 32'h0, 32'h0);
        check("t4_beat2_ov", 32'(bus32.out_valid), 32'd1);
        check("t4_beat2",    bus32.C, 32'h22);
        step();
        check("t4_beat3_ov", 32'(bus32.out_valid), 32'd1);
        check("t4_beat3",    bus32.C, 32'h33);
        step();
        check("t4_empty", 32'(bus32.out_valid), 32'd0);

        // 5: flush a full pipe
        bus32.out_ready = 1'b0;
        drive32(1'b1, 3'b001, 32'h44, 32'hFFFFFFFF);
        step();
        drive32(1'b1, 3'b001, 32'h55, 32'hFFFFFFFF);
        step();
        drive32(1'b1, 3'b001, 32'h66, 32'hFFFFFFFF);
        flush32 = 1'b1;
        #1;
        check("t5_flush_ready", 32'(bus32.in_ready), 32'd0);
        step();
        flush32 = 1'b0;
        drive32(1'b0, 3'd0, 32'h0, 32'h0);
        bus32.out_ready = 1'b1;
        #1;
        check("t5_ov_cleared", 32'(bus32.out_valid), 32'd0);
        check("t5_in_ready",   32'(bus32.in_ready),  32'd1);
        step();
        check("t5_no_accept", 32'(bus32.out_valid), 32'd0);

        // 6: asynchronous reset while stalled with a full pipe
        bus32.out_ready = 1'b0;
        drive32(1'b1, 3'b001, 32'h77, 32'hFFFFFFFF);
        step();
        drive32(1'b1, 3'b001, 32'h88, 32'hFFFFFFFF);
        step();
        drive32(1'b0, 3'd0, 32'h0, 32'h0);
        check("t6_full_ov", 32'(bus32.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ov",     32'(bus32.out_valid), 32'd0);
        check("t6_rst_C",      bus32.C,              32'd0);
        check("t6_rst_zero",   32'(bus32.zero),      32'd1);
        check("t6_rst_parity", 32'(bus32.parity),    32'd0);
        #1;
        rst = 1'b0;
        bus32.out_ready = 1'b1;
        #1;
        check("t6_post_ready", 32'(bus32.in_ready), 32'd1);
        step();
        drive32(1'b1, 3'b010, 32'h00000005, 32'h00000002);
        step();
        drive32(1'b0, 3'd0, 32'h0, 32'h0);
        check("t6_ov_t1", 32'(bus32.out_valid), 32'd0);
        step();
        check("t6_ov_t2",   32'(bus32.out_valid), 32'd1);
        check("t6_C",       bus32.C,              32'h00000007);
        check("t6_zero",    32'(bus32.zero),      32'd0);
        check("t6_parity",  32'(bus32.parity),    32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
